// File: rtl/max_pcx_deser_if.sv
// FSL-side input and PCX-side output bundle for max_pcx_deser.
// MAX_PCX_ERRCNT_EN adds the 8-bit error-count output.
interface max_pcx_deser_if #(
  parameter int PCX_WIDTH = 124
);
  logic                 fsl_pcx_s_exists;
  logic                 fsl_pcx_s_control;
  logic [31:0]          fsl_pcx_s_data;
  logic                 pcx_fsl_s_read;
  logic                 max_pcx_valid;
  logic [PCX_WIDTH-1:0] max_pcx_data;
  logic [4:0]           max_pcx_req;
  logic                 max_pcx_atom;
  logic                 max_pcx_stall;
`ifdef MAX_PCX_ERRCNT_EN
  logic [7:0]           max_pcx_err_cnt;

  modport master (
    output fsl_pcx_s_exists, fsl_pcx_s_control,
    output fsl_pcx_s_data, max_pcx_stall,
    input  pcx_fsl_s_read, max_pcx_valid,
    input  max_pcx_data, max_pcx_req,
    input  max_pcx_atom, max_pcx_err_cnt
  );
  modport slave (
    input  fsl_pcx_s_exists, fsl_pcx_s_control,
    input  fsl_pcx_s_data, max_pcx_stall,
    output pcx_fsl_s_read, max_pcx_valid,
    output max_pcx_data, max_pcx_req,
    output max_pcx_atom, max_pcx_err_cnt
  );
`else
  modport master (
    output fsl_pcx_s_exists, fsl_pcx_s_control,
    output fsl_pcx_s_data, max_pcx_stall,
    input  pcx_fsl_s_read, max_pcx_valid,
    input  max_pcx_data, max_pcx_req,
    input  max_pcx_atom
  );
  modport slave (
    input  fsl_pcx_s_exists, fsl_pcx_s_control,
    input  fsl_pcx_s_data, max_pcx_stall,
    output pcx_fsl_s_read, max_pcx_valid,
    output max_pcx_data, max_pcx_req,
    output max_pcx_atom
  );
`endif
endinterface

// File: rtl/max_pcx_deser.sv
// Deserialises 5-word FSL packets (header + 4 payload) into one PCX packet.
// Define MAX_PCX_ERRCNT_EN to add a saturating orphan/truncation error counter.
module max_pcx_deser #(
  parameter int MAX_D_WIDTH = 32,
  parameter int PCX_WIDTH   = 124
) (
  input  logic            gclk,
  input  logic            reset_l,
  max_pcx_deser_if.slave  bus
);
  localparam int W0W = PCX_WIDTH - 3 * MAX_D_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_cnt;
  logic [4:0]             r_hreq;
  logic                   r_hatom;
  logic [W0W-1:0]         r_w0;
  logic [MAX_D_WIDTH-1:0] r_w1;
  logic [MAX_D_WIDTH-1:0] r_w2;
  logic [PCX_WIDTH-1:0]   r_data;
  logic [4:0]             r_req;
  logic                   r_atom;
  logic                   w_rd;
  logic                   w_hdr;
  logic                   w_store;
  logic                   w_done;
  logic                   w_err;
  logic [MAX_D_WIDTH-1:0] w_word;

  assign w_word = bus.fsl_pcx_s_data;
  assign w_rd = reset_l & bus.fsl_pcx_s_exists
              & (r_state != HOLD);

  assign bus.pcx_fsl_s_read = w_rd;
  assign bus.max_pcx_valid  = (r_state == HOLD);
  assign bus.max_pcx_data   = r_data;
  assign bus.max_pcx_req    = r_req;
  assign bus.max_pcx_atom   = r_atom;

  always_comb begin
    w_next  = r_state;
    w_hdr   = 1'b0;
    w_store = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rd) begin
          if (bus.fsl_pcx_s_control) begin
            w_hdr  = 1'b1;
            w_next = COLLECT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (w_rd) begin
          if (bus.fsl_pcx_s_control) begin
            w_hdr = 1'b1;
            w_err = 1'b1;
          end else begin
            w_store = 1'b1;
            if (r_cnt == 2'd3) begin
              w_done = 1'b1;
              w_next = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!bus.max_pcx_stall) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Payload is staged in shadow words so the outputs move only on completion
  always_ff @(posedge gclk) begin
    if (!reset_l) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hreq  <= '0;
      r_hatom <= 1'b0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_data  <= '0;
      r_req   <= '0;
      r_atom  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hdr) begin
        r_hreq  <= w_word[4:0];
        r_hatom <= w_word[5];
        r_cnt   <= '0;
      end else if (w_store) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_store && r_cnt == 2'd0) r_w0 <= w_word[W0W-1:0];
      if (w_store && r_cnt == 2'd1) r_w1 <= w_word;
      if (w_store && r_cnt == 2'd2) r_w2 <= w_word;
      if (w_done) begin
        r_data <= {r_w0, r_w1, r_w2, w_word};
        r_req  <= r_hreq;
        r_atom <= r_hatom;
      end
    end
  end

`ifdef MAX_PCX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge gclk) begin
    if (!reset_l) begin
      r_err_cnt <= '0;
    end else if (w_err && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.max_pcx_err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_max_pcx_deser.sv
// Table-driven bench for max_pcx_deser with an expected-packet scoreboard.
// Error-count checks are compiled in when MAX_PCX_ERRCNT_EN is defined.
module tb_max_pcx_deser;
  logic gclk = 1'b0;
  logic reset_l = 1'b0;

  always #5 gclk = ~gclk;

  max_pcx_deser_if #(.PCX_WIDTH(124)) bus ();

  max_pcx_deser #(
    .MAX_D_WIDTH(32),
    .PCX_WIDTH(124)
  ) dut (
    .gclk   (gclk),
    .reset_l(reset_l),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]   req;
    logic         atom;
    logic [123:0] data;
    int           hold;
  } pkt_t;

  typedef struct {
    logic [31:0]  hdr;
    logic [31:0]  p0, p1, p2, p3;
    int           st;
    logic [4:0]   req;
    logic         atom;
    logic [123:0] data;
  } vec_t;

  pkt_t        sb[$];
  logic [32:0] wq[$];
  int          rise_hist[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cons = -1;
  int nrise = 0;
  int npkts = 0;
  int exp_pkts = 0;
  int exp_err = 0;
  int hold_cnt = 0;
  logic rd_s = 1'b0;
  logic prev_valid = 1'b0;
  logic [123:0] snap_data;
  logic [4:0]   snap_req;
  logic         snap_atom;
  vec_t tbl[3];

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic push_word(input logic c, input logic [31:0] d);
    wq.push_back({c, d});
  endtask

  task automatic push_pkt(input logic [31:0] h, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d);
    push_word(1'b1, h);
    push_word(1'b0, a);
    push_word(1'b0, b);
    push_word(1'b0, c);
    push_word(1'b0, d);
  endtask

  task automatic expect_pkt(input logic [4:0] r, input logic a,
                            input logic [123:0] d, input int h);
    pkt_t p;
    p.req = r;
    p.atom = a;
    p.data = d;
    p.hold = h;
    sb.push_back(p);
    exp_pkts++;
  endtask

  task automatic wait_sb(input string n);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge gclk);
      #1;
      k++;
    end
    chk(n, sb.size(), 0);
  endtask

  task automatic wait_wq(input string n);
    int k = 0;
    while (wq.size() != 0 && k < 200) begin
      @(negedge gclk);
      #1;
      k++;
    end
    chk(n, wq.size(), 0);
  endtask

  task automatic wait_rise(input int n0);
    int k = 0;
    while (nrise == n0 && k < 100) begin
      @(negedge gclk);
      #1;
      k++;
    end
    chk("valid_seen", nrise != n0, 1'b1);
  endtask

  always @(negedge gclk) rd_s = bus.pcx_fsl_s_read;

  initial begin
    bus.fsl_pcx_s_exists = 1'b0;
    bus.fsl_pcx_s_control = 1'b0;
    bus.fsl_pcx_s_data = '0;
    forever begin
      @(posedge gclk);
      cyc++;
      if (rd_s && wq.size() > 0) begin
        void'(wq.pop_front());
        last_cons = cyc;
      end
      #1;
      if (wq.size() > 0) begin
        bus.fsl_pcx_s_exists = 1'b1;
        bus.fsl_pcx_s_control = wq[0][32];
        bus.fsl_pcx_s_data = wq[0][31:0];
      end else begin
        bus.fsl_pcx_s_exists = 1'b0;
        bus.fsl_pcx_s_control = 1'b0;
        bus.fsl_pcx_s_data = '0;
      end
    end
  end

  always @(negedge gclk) begin
    pkt_t e;
    if (reset_l) begin
      if (bus.max_pcx_valid && !prev_valid) begin
        nrise++;
        rise_hist.push_back(cyc);
        hold_cnt = 0;
        chk("latency", cyc, last_cons);
      end
      if (bus.max_pcx_valid) begin
        hold_cnt++;
        if (prev_valid) begin
          chk("stable_data", bus.max_pcx_data, snap_data);
          chk("stable_req", bus.max_pcx_req, snap_req);
          chk("stable_atom", bus.max_pcx_atom, snap_atom);
        end
        if (bus.fsl_pcx_s_exists)
          chk("hold_no_read", bus.pcx_fsl_s_read, 1'b0);
        snap_data = bus.max_pcx_data;
        snap_req = bus.max_pcx_req;
        snap_atom = bus.max_pcx_atom;
        if (!bus.max_pcx_stall) begin
          npkts++;
          if (sb.size() == 0) begin
            chk("unexpected_pkt", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("pkt_req", bus.max_pcx_req, e.req);
            chk("pkt_atom", bus.max_pcx_atom, e.atom);
            chk("pkt_data", bus.max_pcx_data, e.data);
            chk("hold_len", hold_cnt, e.hold);
          end
        end
      end
      prev_valid = bus.max_pcx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    int n0;
    tbl[0] = '{32'h00000025, 32'h0AAAAAAA, 32'h11111111,
               32'h22222222, 32'h33333333, 0, 5'h05, 1'b1,
               124'hAAAAAAA_11111111_22222222_33333333};
    tbl[1] = '{32'hFFFFFFDA, 32'hF0000001, 32'h80000000,
               32'h00000000, 32'hFFFFFFFF, 0, 5'h1A, 1'b0,
               124'h0000001_80000000_00000000_FFFFFFFF};
    tbl[2] = '{32'h0000003F, 32'h12345678, 32'h9ABCDEF0,
               32'h0F0F0F0F, 32'hF0F0F0F0, 10, 5'h1F, 1'b1,
               124'h2345678_9ABCDEF0_0F0F0F0F_F0F0F0F0};
    bus.max_pcx_stall = 1'b0;
    repeat (3) @(posedge gclk);
    #2;
    chk("rst_valid", bus.max_pcx_valid, 1'b0);
    chk("rst_data", bus.max_pcx_data, 124'h0);
    chk("rst_req", bus.max_pcx_req, 5'h0);
    chk("rst_atom", bus.max_pcx_atom, 1'b0);
    chk("rst_read", bus.pcx_fsl_s_read, 1'b0);
`ifdef MAX_PCX_ERRCNT_EN
    chk("rst_err", bus.max_pcx_err_cnt, 8'd0);
`endif
    reset_l = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge gclk);
      #2;
      bus.max_pcx_stall = (tbl[i].st > 0);
      n0 = nrise;
      push_pkt(tbl[i].hdr, tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3);
      expect_pkt(tbl[i].req, tbl[i].atom, tbl[i].data, tbl[i].st + 1);
      if (tbl[i].st > 0) begin
        push_word(1'b0, 32'hDEADBEEF);
        exp_err++;
      end
      wait_rise(n0);
      if (tbl[i].st > 0) begin
        repeat (tbl[i].st) @(posedge gclk);
        #2;
        bus.max_pcx_stall = 1'b0;
      end
      wait_sb("tbl_drain");
      wait_wq("tbl_words");
    end
`ifdef MAX_PCX_ERRCNT_EN
    chk("err_after_tbl", bus.max_pcx_err_cnt, exp_err);
`endif

    @(posedge gclk);
    #2;
    push_word(1'b1, 32'h00000025);
    push_word(1'b0, 32'h0AAAAAAA);
    push_word(1'b0, 32'h11111111);
    push_pkt(32'h00000003, 32'h04444444, 32'h55555555,
             32'h66666666, 32'h77777777);
    expect_pkt(5'h03, 1'b0, 124'h4444444_55555555_66666666_77777777, 1);
    exp_err++;
    wait_sb("trunc_drain");
`ifdef MAX_PCX_ERRCNT_EN
    chk("err_trunc", bus.max_pcx_err_cnt, exp_err);
`endif

    @(posedge gclk);
    #2;
    push_word(1'b0, 32'hDEADBEEF);
    push_pkt(32'h00000031, 32'h0BBBBBBB, 32'hCCCCCCCC,
             32'hDDDDDDDD, 32'hEEEEEEEE);
    expect_pkt(5'h11, 1'b1, 124'hBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE, 1);
    exp_err++;
    wait_sb("orphan_drain");
`ifdef MAX_PCX_ERRCNT_EN
    chk("err_orphan", bus.max_pcx_err_cnt, exp_err);
`endif

    @(posedge gclk);
    #2;
    push_word(1'b1, 32'h00000025);
    push_word(1'b0, 32'h0AAAAAAA);
    push_word(1'b0, 32'h11111111);
    push_word(1'b0, 32'h22222222);
    wait_wq("partial_words");
    @(posedge gclk);
    #2;
    reset_l = 1'b0;
    exp_err = 0;
    push_pkt(32'h00000025, 32'h0AAAAAAA, 32'h11111111,
             32'h22222222, 32'h33333333);
    repeat (2) @(negedge gclk);
    chk("rst_exists", bus.fsl_pcx_s_exists, 1'b1);
    chk("rst_read_mid", bus.pcx_fsl_s_read, 1'b0);
    chk("rst_data_mid", bus.max_pcx_data, 124'h0);
    chk("rst_req_mid", bus.max_pcx_req, 5'h0);
    chk("rst_valid_mid", bus.max_pcx_valid, 1'b0);
`ifdef MAX_PCX_ERRCNT_EN
    chk("rst_err_mid", bus.max_pcx_err_cnt, 8'd0);
`endif
    @(posedge gclk);
    #2;
    reset_l = 1'b1;
    expect_pkt(5'h05, 1'b1, 124'hAAAAAAA_11111111_22222222_33333333, 1);
    wait_sb("post_rst_drain");

    @(posedge gclk);
    #2;
    push_pkt(32'h00000021, 32'h01010101, 32'h02020202,
             32'h03030303, 32'h04040404);
    push_pkt(32'h00000002, 32'h05050505, 32'h06060606,
             32'h07070707, 32'h08080808);
    expect_pkt(5'h01, 1'b1, 124'h1010101_02020202_03030303_04040404, 1);
    expect_pkt(5'h02, 1'b0, 124'h5050505_06060606_07070707_08080808, 1);
    wait_sb("b2b_drain");
    if (rise_hist.size() >= 2)
      chk("b2b_gap", rise_hist[$] - rise_hist[$-1], 6);
    else
      chk("b2b_rises", rise_hist.size(), 2);

    wait_wq("final_words");
    repeat (5) @(posedge gclk);
    #2;
    chk("sb_empty", sb.size(), 0);
    chk("pkt_count", npkts, exp_pkts);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/max_pcx_deser.md
MAX_PCX_DESER -- requirements
Module: max_pcx_deser

Interface
REQ-001 SHALL have parameter MAX_D_WIDTH, default 32, FSL word width; only 32 is supported.
REQ-002 SHALL have parameter PCX_WIDTH, default 124, PCX packet payload width.
REQ-003 SHALL have port gclk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_l, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port fsl_pcx_s_exists, input, 1, FSL slave FIFO holds a word.
REQ-006 SHALL have port fsl_pcx_s_control, input, 1, marks a header word.
REQ-007 SHALL have port fsl_pcx_s_data, input, 32, FSL word.
REQ-008 SHALL have port pcx_fsl_s_read, output, 1, pops the current FSL word.
REQ-009 SHALL have port max_pcx_valid, output, 1, an assembled packet is presented.
REQ-010 SHALL have port max_pcx_data, output, 124, assembled PCX payload.
REQ-011 SHALL have port max_pcx_req, output, 5, destination request vector from the header.
REQ-012 SHALL have port max_pcx_atom, output, 1, atomic-pair flag from the header.
REQ-013 SHALL have port max_pcx_stall, input, 1, consumer is not accepting.

Function
REQ-014 SHALL treat a packet as 5 words: header (control=1, req=[4:0], atom=[5], bits [31:6] ignored), then 4 payload words (control=0), most-significant word first.
REQ-015 SHALL map payload words 1..4 to bits [123:96], [95:64], [63:32], [31:0]; upper 4 bits of word 1 are discarded.
REQ-016 SHALL drive pcx_fsl_s_read = fsl_pcx_s_exists AND state != HOLD, combinationally; a word is consumed only in a cycle where read=1.
REQ-017 SHALL implement FSM states IDLE, COLLECT, HOLD with a 2-bit payload word counter.
REQ-018 IDLE: consumed word with control=1 latches req/atom, clears counter, goes to COLLECT; a consumed word with control=0 is discarded as an orphan error and the FSM stays in IDLE.
REQ-019 COLLECT: a consumed word with control=0 is stored at counter position and the counter increments; on the 4th word the FSM goes to HOLD.
REQ-020 COLLECT: a consumed word with control=1 is a truncation error; partial data is dropped, the new header is latched, the counter clears, and the FSM stays in COLLECT.
REQ-021 HOLD: max_pcx_valid=1; outputs stay stable while max_pcx_stall=1; at a clock edge with stall=0 the packet is accepted and the FSM goes to IDLE.
REQ-022 SHALL assert max_pcx_valid in the cycle after the 4th payload word is consumed (latency 1 cycle after the last word).
REQ-023 SHALL pass max_pcx_atom unmodified; pairing of atomic packets is the consumer's responsibility.
REQ-024 SHALL not consume FSL words during HOLD; FSL backpressure derives solely from the FIFO.
REQ-025 max_pcx_data/req/atom SHALL be don't-care when valid=0, but SHALL hold their last values (no extra toggling).

Reset
REQ-026 SHALL, with reset_l=0 at a clock edge, set state=IDLE, counter=0, max_pcx_valid=0, max_pcx_data=0, max_pcx_req=0, max_pcx_atom=0, and the error count=0.
REQ-027 SHALL force pcx_fsl_s_read=0 while reset_l=0.
REQ-028 Reset mid-packet or in HOLD SHALL discard the partial or held packet with no valid pulse.

Configuration
REQ-029 Macro MAX_PCX_ERRCNT_EN defined: SHALL add output max_pcx_err_cnt, 8 bits, which increments on each orphan (REQ-018) or truncation (REQ-020) error, saturates at 255, and is cleared only by reset.
REQ-030 Macro MAX_PCX_ERRCNT_EN undefined: the port and counter SHALL be absent; error handling is otherwise identical.

Verification
REQ-031 Words 0x00000025(c=1), 0x0AAAAAAA, 0x11111111, 0x22222222, 0x33333333 with stall=0 -> valid one cycle after the last word; req=5'h05, atom=1, data=124'hAAAAAAA_11111111_22222222_33333333.
REQ-032 Same packet with stall=1 for 10 cycles -> valid held for 11 cycles, outputs stable, read=0 throughout although exists=1.
REQ-033 Header, 2 payload words, then new header 0x00000003 and 4 words -> one valid packet only, req=5'h03, second-packet data; err_cnt=1 when MAX_PCX_ERRCNT_EN is defined.
REQ-034 Orphan word 0xDEADBEEF (c=0) in IDLE followed by a good packet -> orphan discarded, one correct packet, err_cnt=1.
REQ-035 reset_l=0 after the 3rd payload word, then a complete packet -> no valid before reset; exactly one valid after, with correct data.
REQ-036 Two back-to-back packets with exists=1 continuously and stall=0 -> two valid pulses, separated by exactly 5 word-consume cycles plus 1 HOLD cycle.
